// File: rtl/lsu_store_buffer_fwd.sv
// Store buffer for the Clownfish LSU: holds stores until commit, drains committed
// stores in order to the L1 D-cache, and forwards store data to younger loads.
module lsu_store_buffer_fwd #(
    parameter int DEPTH    = 8,
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = 6,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [XLEN-1:0]     alloc_addr_i,
    input  logic [XLEN-1:0]     alloc_data_i,
    input  logic [1:0]          alloc_size_i,
    input  logic [ROB_ID_W-1:0] alloc_rob_id_i,
    input  logic                commit_valid_i,
    input  logic                flush_i,
    input  logic                fwd_req_valid_i,
    input  logic [XLEN-1:0]     fwd_addr_i,
    input  logic [1:0]          fwd_size_i,
    output logic                fwd_valid_o,
    output logic                fwd_hit_o,
    output logic                fwd_conflict_o,
    output logic [XLEN-1:0]     fwd_data_o,
    output logic                dcache_req_valid_o,
    output logic [XLEN-1:0]     dcache_req_addr_o,
    output logic [XLEN-1:0]     dcache_req_data_o,
    output logic [3:0]          dcache_req_be_o,
    input  logic                dcache_req_ready_i,
    input  logic                dcache_resp_valid_i,
    input  logic                dcache_resp_error_i,
    output logic                err_valid_o,
    output logic [ROB_ID_W-1:0] err_rob_id_o,
    output logic                empty_o,
    output logic [CNT_W-1:0]    count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } drain_state_t;

    typedef struct packed {
        logic [XLEN-3:0]     word;
        logic [XLEN-1:0]     data;
        logic [3:0]          be;
        logic [ROB_ID_W-1:0] rob_id;
    } entry_t;

    entry_t              ent_q [DEPTH];
    logic [DEPTH-1:0]    vld_q, cmt_q;
    logic [PTR_W-1:0]    head_q, tail_q, cptr_q;
    logic [CNT_W-1:0]    cnt_q;   // occupied entries
    logic [CNT_W-1:0]    ccnt_q;  // committed, not yet retired entries
    drain_state_t        state_q, state_d;

    logic                alloc_fire, commit_fire, retire;
    logic [3:0]          fwd_mask;
    logic                fwd_found, fwd_hit_d, fwd_conf_d;
    logic [XLEN-1:0]     fwd_data_d;
    logic [PTR_W-1:0]    fwd_idx;

    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    assign alloc_ready_o = (cnt_q < CNT_W'(DEPTH));
    assign empty_o       = (cnt_q == '0);
    assign count_o       = cnt_q;

    assign alloc_fire  = alloc_valid_i && alloc_ready_o && !flush_i;
    // An uncommitted entry exists exactly when occupancy exceeds committed occupancy.
    assign commit_fire = commit_valid_i && !flush_i && (cnt_q != ccnt_q);
    assign retire      = (state_q == S_WAIT) && dcache_resp_valid_i;

    // Request fields come straight from the head entry; head is frozen until retire.
    assign dcache_req_valid_o = (state_q == S_REQ);
    assign dcache_req_addr_o  = dcache_req_valid_o ? {ent_q[head_q].word, 2'b00} : '0;
    assign dcache_req_data_o  = dcache_req_valid_o ? ent_q[head_q].data : '0;
    assign dcache_req_be_o    = dcache_req_valid_o ? ent_q[head_q].be : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (vld_q[head_q] && cmt_q[head_q]) state_d = S_REQ;
            S_REQ:   if (dcache_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (dcache_resp_valid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Youngest-to-oldest search; the first overlapping entry decides hit or conflict.
    always_comb begin
        fwd_mask   = size_to_be(fwd_size_i, fwd_addr_i[1:0]);
        fwd_found  = 1'b0;
        fwd_hit_d  = 1'b0;
        fwd_conf_d = 1'b0;
        fwd_data_d = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = tail_q - PTR_W'(k + 1);
            if (!fwd_found && vld_q[fwd_idx] &&
                (ent_q[fwd_idx].word == fwd_addr_i[XLEN-1:2]) &&
                ((ent_q[fwd_idx].be & fwd_mask) != 4'b0000)) begin
                fwd_found = 1'b1;
                if ((ent_q[fwd_idx].be & fwd_mask) == fwd_mask) begin
                    fwd_hit_d  = 1'b1;
                    fwd_data_d = ent_q[fwd_idx].data;
                end else begin
                    fwd_conf_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            vld_q          <= '0;
            cmt_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            cptr_q         <= '0;
            cnt_q          <= '0;
            ccnt_q         <= '0;
            fwd_valid_o    <= 1'b0;
            fwd_hit_o      <= 1'b0;
            fwd_conflict_o <= 1'b0;
            fwd_data_o     <= '0;
            err_valid_o    <= 1'b0;
            err_rob_id_o   <= '0;
        end else begin
            state_q        <= state_d;
            fwd_valid_o    <= fwd_req_valid_i;
            fwd_hit_o      <= fwd_req_valid_i && fwd_hit_d;
            fwd_conflict_o <= fwd_req_valid_i && fwd_conf_d;
            fwd_data_o     <= fwd_req_valid_i ? fwd_data_d : '0;
            err_valid_o    <= retire && dcache_resp_error_i;
            err_rob_id_o   <= (retire && dcache_resp_error_i) ? ent_q[head_q].rob_id : '0;

            if (retire) begin
                vld_q[head_q] <= 1'b0;
                cmt_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end

            if (flush_i) begin
                // Committed entries survive; everything younger is discarded.
                for (int i = 0; i < DEPTH; i++) begin
                    if (!cmt_q[i]) vld_q[i] <= 1'b0;
                end
                tail_q <= cptr_q;
                cnt_q  <= ccnt_q - CNT_W'(retire);
                ccnt_q <= ccnt_q - CNT_W'(retire);
            end else begin
                if (alloc_fire) begin
                    vld_q[tail_q] <= 1'b1;
                    tail_q        <= tail_q + PTR_W'(1);
                end
                if (commit_fire) begin
                    cmt_q[cptr_q] <= 1'b1;
                    cptr_q        <= cptr_q + PTR_W'(1);
                end
                cnt_q  <= cnt_q + CNT_W'(alloc_fire) - CNT_W'(retire);
                ccnt_q <= ccnt_q + CNT_W'(commit_fire) - CNT_W'(retire);
            end
        end
    end

    // NOTE: entry payload is storage qualified by vld_q, so it is deliberately not reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_q[tail_q].word   <= alloc_addr_i[XLEN-1:2];
            ent_q[tail_q].data   <= alloc_data_i << {alloc_addr_i[1:0], 3'b000};
            ent_q[tail_q].be     <= size_to_be(alloc_size_i, alloc_addr_i[1:0]);
            ent_q[tail_q].rob_id <= alloc_rob_id_i;
        end
    end

endmodule
